// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and operand signedness helpers.
package mul_div_unit_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [4:0] ITER_LOAD = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling around the unsigned iteration: operand magnitude/sign
// extraction at start, conditional negation of product/quotient/remainder at completion.
module mdu_sign_fix
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_res,
    output logic              neg_rem,
    input  logic [2*XLEN-1:0] prod_mag,
    input  logic [XLEN-1:0]   quo_mag,
    input  logic [XLEN-1:0]   rem_mag,
    input  logic              neg_res_q,
    input  logic              neg_rem_q,
    output logic [2*XLEN-1:0] prod_fix,
    output logic [XLEN-1:0]   quo_fix,
    output logic [XLEN-1:0]   rem_fix
);

    logic sign_a;
    logic sign_b;

    always_comb begin
        sign_a  = op_signed_a(op) & a[XLEN-1];
        sign_b  = op_signed_b(op) & b[XLEN-1];
        mag_a   = sign_a ? -a : a;
        mag_b   = sign_b ? -b : b;
        neg_res = sign_a ^ sign_b;
        // remainder takes the dividend's sign
        neg_rem = sign_a;
    end

    always_comb begin
        prod_fix = neg_res_q ? -prod_mag : prod_mag;
        quo_fix  = neg_res_q ? -quo_mag  : quo_mag;
        rem_fix  = neg_rem_q ? -rem_mag  : rem_mag;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, 32 iterations per op, single-cycle fast path for divide-by-zero/overflow.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_e        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [2:0]        op_q, op_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_res, neg_rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] iter_next;
    logic              accept;
    logic              b_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN-1:0]   calc_res;

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op        (op),
        .a         (a),
        .b         (b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_res   (neg_res),
        .neg_rem   (neg_rem),
        .prod_mag  (iter_next),
        .quo_mag   (iter_next[XLEN-1:0]),
        .rem_mag   (iter_next[2*XLEN-1:XLEN]),
        .neg_res_q (neg_res_q),
        .neg_rem_q (neg_rem_q),
        .prod_fix  (prod_fix),
        .quo_fix   (quo_fix),
        .rem_fix   (rem_fix)
    );

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvs_q};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, dvs_q};
        if (op_q[2]) begin
            if (div_trial[XLEN]) begin
                iter_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                iter_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else if (acc_q[0]) begin
            iter_next = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            iter_next = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    always_comb begin
        b_zero  = (b == '0);
        div_ovf = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        fast    = op[2] & (b_zero | div_ovf);
        if (b_zero) begin
            fast_res = op[1] ? a : '1;
        end else begin
            fast_res = op[1] ? '0 : a;
        end
    end

    always_comb begin
        case (op_q)
            MD_MUL:                       calc_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              calc_res = quo_fix;
            default:                      calc_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        accept    = start & ~flush & (state_q != ST_CALC);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    op_d      = op;
                    neg_res_d = neg_res;
                    neg_rem_d = neg_rem;
                    cnt_d     = ITER_LOAD;
                    acc_d     = {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
                    dvs_d     = op[2] ? mag_b : mag_a;
                    if (fast) begin
                        state_d  = ST_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = iter_next;
                    if (cnt_q == 5'd0) begin
                        state_d  = ST_DONE;
                        result_d = calc_res;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
